// File: rtl/axi_lite_regfile_ctrl.sv
// axi_lite_regfile_ctrl
//   Register bank on the register-file side of axi_lite_regs_if.
//   Holds ID, CTRL, CMD, W1C STATUS, event/cycle counters and 8 scratch words.
//   It drives the datapath enable, a one-cycle start pulse and a level interrupt.
// Ports
//   s_axi_aclk, s_axi_reset : clock, synchronous active-high reset
//   axi_write_fire, wr_addr, wr_data, wr_strb : single-cycle write commit
//   axi_read_fire, rd_addr, rd_data           : combinational read port
//   evt_i, done_i                             : datapath event / done strobes
//   ctrl_enable_o, start_o, irq_o             : datapath control outputs
module axi_lite_regfile_ctrl #(
  parameter int          ADDR_WIDTH = 6,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] ID_VALUE   = 32'hDF40_0001
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_reset,
  input  logic                    axi_write_fire,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    axi_read_fire,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    evt_i,
  input  logic                    done_i,
  output logic                    ctrl_enable_o,
  output logic                    start_o,
  output logic                    irq_o
);

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("axi_lite_regfile_ctrl: DATA_WIDTH must be 32");
  end

  localparam logic [ADDR_WIDTH-1:0] A_ID     = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_CMD    = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_EVT    = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_CYCLE  = ADDR_WIDTH'(5);

  logic [2:0]            r_ctrl;
  logic [1:0]            r_status;
  logic [DATA_WIDTH-1:0] r_evt_cnt;
  logic [DATA_WIDTH-1:0] r_cyc_cnt;
  logic [DATA_WIDTH-1:0] r_scratch [0:7];
  logic                  r_start;
  logic                  r_irq;

  logic       w_wr_ctrl;
  logic       w_wr_scr;
  logic       w_cmd_start;
  logic       w_cmd_clr;
  logic [1:0] w_w1c;
  logic       w_evt_inc;
  logic       w_evt_wrap;
  logic       w_evt_clr;
  logic       w_rd_scr;

  function automatic logic [DATA_WIDTH-1:0] f_merge(
    input logic [DATA_WIDTH-1:0]   old_v,
    input logic [DATA_WIDTH-1:0]   new_v,
    input logic [DATA_WIDTH/8-1:0] strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_v;
    for (int unsigned i = 0; i < DATA_WIDTH/8; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return res;
  endfunction

  always_comb begin
    w_wr_ctrl   = axi_write_fire && (wr_addr == A_CTRL);
    w_wr_scr    = axi_write_fire && (wr_addr[ADDR_WIDTH-1:3] == (ADDR_WIDTH-3)'(1));
    w_cmd_start = axi_write_fire && (wr_addr == A_CMD) && wr_strb[0] && wr_data[0];
    w_cmd_clr   = axi_write_fire && (wr_addr == A_CMD) && wr_strb[0] && wr_data[1];
    w_w1c       = (axi_write_fire && (wr_addr == A_STATUS) && wr_strb[0]) ? wr_data[1:0] : '0;
    w_evt_inc   = evt_i && r_ctrl[0];
    w_evt_wrap  = w_evt_inc && (&r_evt_cnt);
    // Clear-on-read acts on the capture pulse, so the bus already holds the old value.
    w_evt_clr   = w_cmd_clr || (axi_read_fire && (rd_addr == A_EVT) && r_ctrl[2]);
    w_rd_scr    = (rd_addr[ADDR_WIDTH-1:3] == (ADDR_WIDTH-3)'(1));
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_reset) begin
      r_ctrl    <= '0;
      r_status  <= '0;
      r_evt_cnt <= '0;
      r_cyc_cnt <= '0;
      r_start   <= 1'b0;
      r_irq     <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) r_scratch[i] <= '0;
    end else begin
      if (w_wr_ctrl && wr_strb[0]) r_ctrl <= wr_data[2:0];
      if (w_wr_scr) r_scratch[wr_addr[2:0]] <= f_merge(r_scratch[wr_addr[2:0]], wr_data, wr_strb);

      // Hardware set is OR-ed in after the W1C mask so it wins a same-cycle clear.
      r_status <= (r_status & ~w_w1c) | {w_evt_wrap, done_i};

      // A clear coinciding with an event leaves the counter at 1, not 0.
      if (w_evt_clr)      r_evt_cnt <= DATA_WIDTH'(w_evt_inc);
      else if (w_evt_inc) r_evt_cnt <= r_evt_cnt + 1'b1;

      if (w_cmd_clr)      r_cyc_cnt <= '0;
      else if (r_ctrl[0]) r_cyc_cnt <= r_cyc_cnt + 1'b1;

      r_start <= w_cmd_start;
      r_irq   <= r_ctrl[1] && (|r_status);
    end
  end

  always_comb begin
    rd_data = '0;
    if (w_rd_scr) begin
      rd_data = r_scratch[rd_addr[2:0]];
    end else begin
      case (rd_addr)
        A_ID:     rd_data = ID_VALUE;
        A_CTRL:   rd_data = {{(DATA_WIDTH-3){1'b0}}, r_ctrl};
        A_STATUS: rd_data = {{(DATA_WIDTH-2){1'b0}}, r_status};
        A_EVT:    rd_data = r_evt_cnt;
        A_CYCLE:  rd_data = r_cyc_cnt;
        default:  rd_data = '0;
      endcase
    end
  end

  assign ctrl_enable_o = r_ctrl[0];
  assign start_o       = r_start;
  assign irq_o         = r_irq;

endmodule
